// File: rtl/elm_pkg.sv
// Shared definitions for the ELM hidden-layer engine: weight LFSR, its step
// function and the controller state encoding.
package elm_pkg;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'h37DD;

   localparam int TAP_A = 5;
   localparam int TAP_B = 3;
   localparam int TAP_C = 2;
   localparam int TAP_D = 0;

   typedef logic [LFSR_W-1:0] lfsr_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT,
      DONE
   } state_t;

   // One step: feedback shifted in at the top, then the result is folded with
   // its own one-bit rotation to spread the weight bits.
   function automatic lfsr_t lfsr_next(input lfsr_t s);
      lfsr_t x;
      x = {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
      return x ^ {x[0], x[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/elm_hidden_layer_engine_if.sv
// Start/result handshake bundle between the image loader, the hidden-layer
// engine and the output-layer MAC.
interface elm_hidden_layer_engine_if #(
   parameter int IN_BITS  = 256,
   parameter int ACC_BITS = 21,
   parameter int IDX_BITS = 9
);

   logic                start;
   logic [IN_BITS-1:0]  image_data;
   logic                busy;
   logic                h_valid;
   logic                h_ready;
   logic [ACC_BITS-1:0] h_data;
   logic [IDX_BITS-1:0] h_index;
   logic                done;

   modport master (
      output start, image_data, h_ready,
      input  busy, h_valid, h_data, h_index, done
   );

   modport slave (
      input  start, image_data, h_ready,
      output busy, h_valid, h_data, h_index, done
   );

endinterface

// File: rtl/elm_lfsr_unroll.sv
// Combinational LFSR unroll: the LANES weights for this cycle and the state
// LANES steps ahead.
module elm_lfsr_unroll
   import elm_pkg::*;
#(
   parameter int LANES = 1
) (
   input  lfsr_t              state_i,
   output lfsr_t [LANES-1:0]  weights_o,
   output lfsr_t              next_o
);

   lfsr_t walk;

   // Lane k sees the state advanced k times, so lane 0 pairs with the lowest pixel
   always_comb begin
      walk      = state_i;
      weights_o = '0;
      for (int k = 0; k < LANES; k++) begin
         weights_o[k] = walk;
         walk         = lfsr_next(walk);
      end
      next_o = walk;
   end

endmodule

// File: rtl/elm_hidden_layer_engine.sv
// ELM hidden layer: accumulates LFSR weights over the set pixels of a binary
// image for each hidden node and streams act(sum) out over valid/ready.
module elm_hidden_layer_engine
   import elm_pkg::*;
#(
   parameter int    IN_BITS   = 256,
   parameter int    HIDDEN    = 300,
   parameter int    LANES     = 1,
   parameter int    W_BITS    = 16,
   parameter int    ACC_BITS  = 21,
   parameter lfsr_t LFSR_SEED = LFSR_SEED_DEFAULT,
   parameter bit    RELU_EN   = 1'b1,
   parameter bit    SATURATE  = 1'b0
) (
   input logic                       clock,
   input logic                       reset,
   elm_hidden_layer_engine_if.slave  bus
);

   localparam int CNT_BITS = $clog2(IN_BITS + 1);
   localparam int IDX_BITS = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(IN_BITS - LANES);
   localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(HIDDEN - 1);
   localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

   state_t                     state_q, state_d;
   lfsr_t                      lfsr_q, lfsr_d, lfsr_adv;
   lfsr_t [LANES-1:0]          weights;
   logic signed [ACC_BITS-1:0] acc_q, acc_d, acc_sum;
   logic [IN_BITS-1:0]         img_q, img_d;
   logic [CNT_BITS-1:0]        cnt_q, cnt_d;
   logic [IDX_BITS-1:0]        node_q, node_d;
   logic [IDX_BITS-1:0]        h_index_q, h_index_d;
   logic [ACC_BITS-1:0]        h_data_q, h_data_d;
   logic                       busy_q, busy_d;
   logic                       h_valid_q, h_valid_d;
   logic                       done_q, done_d;
   logic [LANES-1:0]           lane_bits;

   function automatic logic signed [ACC_BITS-1:0] widen(input lfsr_t w);
      return {{(ACC_BITS-W_BITS){w[W_BITS-1]}}, w[W_BITS-1:0]};
   endfunction

   // One extra bit exposes signed overflow; clamp it or let it wrap.
   function automatic logic signed [ACC_BITS-1:0] sat_add(
      input logic signed [ACC_BITS-1:0] a,
      input logic signed [ACC_BITS-1:0] b
   );
      logic signed [ACC_BITS:0] s;
      s = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
      if (SATURATE && (s[ACC_BITS] != s[ACC_BITS-1]))
         return s[ACC_BITS] ? ACC_MIN : ACC_MAX;
      return s[ACC_BITS-1:0];
   endfunction

   function automatic logic [ACC_BITS-1:0] act(input logic signed [ACC_BITS-1:0] v);
      return (RELU_EN && v[ACC_BITS-1]) ? '0 : v;
   endfunction

   elm_lfsr_unroll #(.LANES(LANES)) u_unroll (
      .state_i   (lfsr_q),
      .weights_o (weights),
      .next_o    (lfsr_adv)
   );

   // Pixels are MSB-first, so lane_bits[LANES-1] is pixel cnt_q.
   assign lane_bits = LANES'(img_q >> (CNT_LAST - cnt_q));

   always_comb begin
      acc_sum = acc_q;
      for (int k = 0; k < LANES; k++) begin
         if (lane_bits[LANES-1-k])
            acc_sum = sat_add(acc_sum, widen(weights[k]));
      end
   end

   // Controller; every output is registered and set on the transition that
   // enters the state in which it must be visible.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      acc_d     = acc_q;
      img_d     = img_q;
      cnt_d     = cnt_q;
      node_d    = node_q;
      h_index_d = h_index_q;
      h_data_d  = h_data_q;
      busy_d    = busy_q;
      h_valid_d = h_valid_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               img_d   = bus.image_data;
               lfsr_d  = LFSR_SEED;
               acc_d   = '0;
               cnt_d   = '0;
               node_d  = '0;
               busy_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d  = acc_sum;
            lfsr_d = lfsr_adv;
            cnt_d  = cnt_q + CNT_BITS'(LANES);
            if (cnt_q == CNT_LAST) begin
               state_d   = EMIT;
               h_valid_d = 1'b1;
               h_data_d  = act(acc_sum);
               h_index_d = node_q;
            end
         end
         EMIT: begin
            if (bus.h_ready) begin
               h_valid_d = 1'b0;
               acc_d     = '0;
               cnt_d     = '0;
               if (node_q == IDX_LAST) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  node_d  = node_q + IDX_BITS'(1);
                  state_d = ACCUM;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         lfsr_q    <= LFSR_SEED;
         acc_q     <= '0;
         img_q     <= '0;
         cnt_q     <= '0;
         node_q    <= '0;
         h_index_q <= '0;
         h_data_q  <= '0;
         busy_q    <= 1'b0;
         h_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         acc_q     <= acc_d;
         img_q     <= img_d;
         cnt_q     <= cnt_d;
         node_q    <= node_d;
         h_index_q <= h_index_d;
         h_data_q  <= h_data_d;
         busy_q    <= busy_d;
         h_valid_q <= h_valid_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.h_valid = h_valid_q;
   assign bus.h_data  = h_data_q;
   assign bus.h_index = h_index_q;
   assign bus.done    = done_q;

endmodule

// File: doc/elm_hidden_layer_engine.md
Name: elm_hidden_layer_engine

Overview:
- Parametrised ELM hidden-layer engine.
- Computes every hidden-node value H[h] = act(sum over i of x[i]·W[h][i]), for a binary input image x against a fixed LFSR-generated weight matrix.
- Streams results out one node at a time over a valid/ready port, instead of one flattened bus.
- Sits between the image loader and the output-layer MAC. Adds a start/done handshake, LANES-wide bit parallelism, backpressure, optional ReLU bypass and optional saturation.

Parameters:
- IN_BITS, 256, input pixels per image; must be a multiple of LANES.
- HIDDEN, 300, number of hidden nodes.
- LANES, 1, input bits consumed per cycle (1, 2, 4 or 8).
- W_BITS, 16, weight width; also the LFSR width.
- ACC_BITS, 21, accumulator and output width; must be ≥ W_BITS+1.
- LFSR_SEED, 16'h37DD, LFSR state loaded at reset and on every accepted start.
- RELU_EN, 1, 1 = ReLU on output; 0 = raw signed sum.
- SATURATE, 0, 1 = clamp the accumulator at signed min/max; 0 = wrap modulo 2^ACC_BITS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- image_data  in  IN_BITS  image; bit IN_BITS-1 is pixel 1 (MSB-first). Captured on the start-accept cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- h_valid  out  1  h_data/h_index are valid.
- h_ready  in  1  consumer accepts the word when h_valid && h_ready.
- h_data  out  ACC_BITS  hidden-node value, two's complement.
- h_index  out  clog2(HIDDEN)  node number, 0-based.
- done  out  1  one-cycle pulse after the last node is accepted.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, LFSR=LFSR_SEED, accumulator=0, image register=0, counters=0. busy, h_valid, done, h_data and h_index are all 0.
- LFSR step on state s[15:0]:
  - taps = s[5]^s[3]^s[2]^s[0]
  - x = {taps, s[15:1]}
  - next = x ^ {x[0], x[15:1]}
- Weight: W = the current LFSR state read as signed W_BITS, sign-extended to ACC_BITS. The first weight is the seed itself.
- Weight order: W[h][i] is the seed advanced (h·IN_BITS + i) times. The LFSR advances once per input bit, whether the pixel is 0 or 1. It never advances in EMIT or while stalled.
- FSM states:
  - IDLE: on start, latch image_data, reload the seed, clear the accumulator, set h=0, i=0, go to ACCUM.
  - ACCUM: each cycle, add the weights for pixels i..i+LANES-1 where the pixel is 1. Advance the LFSR LANES steps and set i += LANES. When i reaches IN_BITS, go to EMIT.
  - EMIT: assert h_valid with h_data = act(acc) and h_index = h. Hold until h_ready. On transfer, clear the accumulator and set i=0. If h = HIDDEN-1, go to DONE; otherwise h++ and return to ACCUM.
  - DONE: pulse done for one cycle, go to IDLE.
- Activation: with RELU_EN=1, h_data = 0 if acc[ACC_BITS-1] is set, else acc. With RELU_EN=0, h_data = acc.
- Overflow: with SATURATE=0, wrap modulo 2^ACC_BITS. With SATURATE=1, clamp to 2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1).
- Latency: start → first h_valid is IN_BITS/LANES + 1 cycles. Minimum total is HIDDEN·(IN_BITS/LANES + 1) + 1 cycles.
- Held outputs: h_data and h_index stay stable while h_valid && !h_ready.
- start while busy is ignored. image_data changes after capture have no effect.
- reset asserted mid-operation aborts immediately to the reset state. No done is produced.

Decomposition:
- elm_pkg holds:
  - LFSR_SEED_DEFAULT and the tap positions;
  - function lfsr_next(state);
  - the FSM state enum (IDLE, ACCUM, EMIT, DONE).
- Sub-module elm_lfsr_unroll (parameter LANES):
  - combinational; takes the current state;
  - outputs LANES consecutive states (the weights) plus the state LANES steps ahead.

Test Plan:
- Weight stream: reset, then start. With IN_BITS=4, HIDDEN=2, image=4'b1000 → node0 = 14301 (0x37DD). Second LFSR state = 0xD619.
- Signed sum and ReLU: image 4'b1100 → node0 = 14301 + (-10727) = 3574. Image 4'b0100 with RELU_EN=1 → 0. Same image with RELU_EN=0 → 21'h1FD619.
- Full default config: image all zeros → 300 words, all 0, h_index 0..299 in order. Exactly one done pulse. Cycle count 300·257 + 1.
- LANES equivalence: random image, LANES=1 vs LANES=4 → identical h_data sequence. The LANES=4 run shows per-node ACCUM time of 64 cycles.
- Backpressure: drop h_ready for 5 cycles during EMIT → h_data and h_index stay stable, LFSR frozen. Results match the no-stall run.
- Control corners:
  - start asserted mid-run → ignored.
  - reset asserted at node 150 → all outputs 0 immediately.
  - restart after reset → node0 matches the first run (seed reloaded).
  - SATURATE=1 with ACC_BITS=17 and all-ones image → clamp at 65535 or -65536, no wrap.
